// File: rtl/step_seq.sv
// Step sequencer: walks a small pattern memory at a programmable tempo,
// emitting an oscillator count, a one-cycle trigger and a timed note gate per step.
module step_seq #(
  parameter int NSTEPS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic [15:0]                 tempo_div,
  input  logic [15:0]                 gate_len,
  input  logic [$clog2(NSTEPS)-1:0]   last_step,
  input  logic                        wr_en,
  input  logic [$clog2(NSTEPS)-1:0]   wr_addr,
  input  logic [32:0]                 wr_data,
  output logic [31:0]                 osc_count,
  output logic                        trig,
  output logic                        gate,
  output logic [$clog2(NSTEPS)-1:0]   step_idx,
  output logic                        busy
);

  localparam int AW = $clog2(NSTEPS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [15:0]     tick_q;
  logic [15:0]     gcnt_q;
  logic [32:0]     mem_q [NSTEPS];

  logic            tick_hit_d;
  logic [AW-1:0]   nxt_idx_d;
  logic [AW-1:0]   ld_idx_d;
  logic [32:0]     ld_ent_d;

  // Step to load on this edge: entry 0 when starting, otherwise the successor.
  always_comb begin
    tick_hit_d = (tick_q == tempo_div);
    nxt_idx_d  = (step_idx >= last_step) ? '0 : step_idx + AW'(1);
    ld_idx_d   = (state_q == IDLE) ? '0 : nxt_idx_d;
    ld_ent_d   = mem_q[ld_idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      gcnt_q    <= '0;
      osc_count <= '0;
      trig      <= 1'b0;
      gate      <= 1'b0;
      step_idx  <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < NSTEPS; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q   <= RUN;
            busy      <= 1'b1;
            step_idx  <= '0;
            tick_q    <= '0;
            osc_count <= ld_ent_d[31:0];
            trig      <= ld_ent_d[32];
            gate      <= ld_ent_d[32];
            gcnt_q    <= '0;
          end
        end
        RUN: begin
          // Stopping wins over a boundary landing on the same cycle.
          if (!run) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            trig     <= 1'b0;
            gate     <= 1'b0;
            step_idx <= '0;
            tick_q   <= '0;
            gcnt_q   <= '0;
          end else if (tick_hit_d) begin
            tick_q    <= '0;
            step_idx  <= nxt_idx_d;
            osc_count <= ld_ent_d[31:0];
            trig      <= ld_ent_d[32];
            gate      <= ld_ent_d[32];
            gcnt_q    <= '0;
          end else begin
            tick_q <= tick_q + 16'd1;
            trig   <= 1'b0;
            if (gate) begin
              if (gcnt_q == gate_len) gate <= 1'b0;
              else gcnt_q <= gcnt_q + 16'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_seq.sv
// Bench for step_seq: trigger events are checked by a scoreboard monitor,
// gate/index/busy behaviour by directed per-cycle checks.
module tb_step_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] tempo_div;
  logic [15:0] gate_len;
  logic [2:0]  last_step;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [32:0] wr_data;
  logic [31:0] osc_count;
  logic        trig;
  logic        gate;
  logic [2:0]  step_idx;
  logic        busy;

  step_seq #(.NSTEPS(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .tempo_div(tempo_div),
    .gate_len(gate_len), .last_step(last_step), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .osc_count(osc_count),
    .trig(trig), .gate(gate), .step_idx(step_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          idx;
    logic [31:0] osc;
    int          c;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input int idx, input logic [31:0] osc, input int c);
    exp_t e;
    e.idx = idx; e.osc = osc; e.c = c;
    sbq.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every trigger pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && trig === 1'b1) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_trig: step_idx=%0d osc=0x%0h cycle %0d", step_idx, osc_count, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (step_idx !== 3'(e.idx) || osc_count !== e.osc || cyc != e.c) begin
          fails++;
          $display("FAIL trig_event: got idx=%0d osc=0x%0h cyc=%0d expected idx=%0d osc=0x%0h cyc=%0d",
                   step_idx, osc_count, cyc, e.idx, e.osc, e.c);
        end
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [32:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  int t0;
  int seg;
  int idx2 [7] = '{0, 1, 2, 3, 0, 1, 0};
  logic [31:0] osc2 [7] = '{32'h100, 32'h200, 32'h777, 32'h400, 32'hABC, 32'h200, 32'hABC};
  logic [31:0] osc3 [4] = '{32'hABC, 32'h200, 32'h300, 32'h400};

  initial begin
    rst_n = 1'b0; run = 1'b0; tempo_div = 16'd9; gate_len = 16'd4; last_step = 3'd3;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_trig", trig, 0);
    check("rst_gate", gate, 0);
    check("rst_osc", osc_count, 0);
    check("rst_idx", step_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Basic run, then stop at tick 5 of step 1.
    for (int i = 0; i < 4; i++) wr(3'(i), {1'b1, 32'h100 * (i + 1)});
    @(negedge clk);
    run = 1'b1; t0 = cyc;
    for (int k = 0; k < 6; k++) push(k % 4, 32'h100 * ((k % 4) + 1), t0 + 1 + 10 * k);
    for (int o = 0; o <= 55; o++) begin
      @(negedge clk);
      check("run1_gate", gate, ((o % 10) < 5) ? 1 : 0);
      check("run1_busy", busy, 1);
      check("run1_idx", step_idx, (o / 10) % 4);
    end
    run = 1'b0;
    @(negedge clk);
    check("stop_busy", busy, 0);
    check("stop_gate", gate, 0);
    check("stop_trig", trig, 0);
    check("stop_idx", step_idx, 0);
    check("stop_osc_hold", osc_count, 32'h200);

    // Restart with a disabled step 2, then shrink and live-write while at step 3.
    wr(3'd2, {1'b0, 32'h777});
    @(negedge clk);
    run = 1'b1; t0 = cyc;
    for (int s = 0; s < 7; s++) if (s != 2) push(idx2[s], osc2[s], t0 + 1 + 10 * s);
    for (int o = 0; o <= 65; o++) begin
      @(negedge clk);
      seg = o / 10;
      check("run2_idx", step_idx, idx2[seg]);
      check("run2_osc", osc_count, osc2[seg]);
      check("run2_gate", gate, (seg != 2 && (o % 10) < 5) ? 1 : 0);
      if (o == 35) begin
        last_step = 3'd1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = {1'b1, 32'hABC};
      end
      if (o == 36) wr_en = 1'b0;
    end
    run = 1'b0;
    @(negedge clk);
    check("stop2_busy", busy, 0);
    check("stop2_osc_hold", osc_count, 32'hABC);

    // Gate longer than the step, then async reset between edges.
    wr(3'd2, {1'b1, 32'h300});
    tempo_div = 16'd3; gate_len = 16'd20; last_step = 3'd3;
    @(negedge clk);
    run = 1'b1; t0 = cyc;
    for (int k = 0; k < 8; k++) push(k % 4, osc3[k % 4], t0 + 1 + 4 * k);
    for (int o = 0; o <= 31; o++) begin
      @(negedge clk);
      check("long_gate", gate, 1);
    end
    #2;
    rst_n = 1'b0; run = 1'b0;
    #1;
    check("arst_gate", gate, 0);
    check("arst_trig", trig, 0);
    check("arst_busy", busy, 0);
    check("arst_idx", step_idx, 0);
    check("arst_osc", osc_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", busy, 0);

    // Every entry must read back disabled with count 0.
    tempo_div = 16'd0; last_step = 3'd7; gate_len = 16'd4;
    run = 1'b1;
    for (int o = 0; o < 8; o++) begin
      @(negedge clk);
      check("clr_osc", osc_count, 0);
      check("clr_gate", gate, 0);
      check("clr_idx", step_idx, o);
    end
    run = 1'b0;

    // One step per cycle: trigger stays high across consecutive enabled steps.
    wr(3'd0, {1'b1, 32'h11});
    wr(3'd1, {1'b1, 32'h22});
    last_step = 3'd1; gate_len = 16'd0;
    @(negedge clk);
    run = 1'b1; t0 = cyc;
    for (int k = 0; k < 8; k++) push(k % 2, (k % 2) ? 32'h22 : 32'h11, t0 + 1 + k);
    for (int o = 0; o < 8; o++) begin
      @(negedge clk);
      check("fast_gate", gate, 1);
      check("fast_trig", trig, 1);
    end
    run = 1'b0;
    @(negedge clk);
    check("fast_stop_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
